// File: rtl/dsram_port_arb.sv
// dsram_port_arb: two-port arbiter in front of the single-ported data SRAM.
// Grants at most one AGU access per cycle, steers its fields to the SRAM and
// returns load data to the granted port one cycle later. A dcache miss
// (mem_stall) freezes grants, holds the SRAM request and freezes the return.
//
// Handshake: reqN_en is a valid that must stay asserted with wen/addr/wdata
// unchanged until reqN_gnt is seen high in the same cycle; gnt is the ready.
// reqN_rvalid is a one-cycle pulse with no back-pressure.
module dsram_port_arb #(
    parameter bit RR    = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_stall,
    input  logic             req0_en,
    input  logic [3:0]       req0_wen,
    input  logic [31:0]      req0_addr,
    input  logic [31:0]      req0_wdata,
    output logic             req0_gnt,
    output logic             req0_rvalid,
    output logic [31:0]      req0_rdata,
    input  logic             req1_en,
    input  logic [3:0]       req1_wen,
    input  logic [31:0]      req1_addr,
    input  logic [31:0]      req1_wdata,
    output logic             req1_gnt,
    output logic             req1_rvalid,
    output logic [31:0]      req1_rdata,
    output logic             data_sram_en,
    output logic [3:0]       data_sram_wen,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    input  logic [31:0]      data_sram_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic             prio_ptr;
    logic             ret_valid;
    logic             ret_sel;
    logic [CNT_W-1:0] cnt_q;
    logic             hold_en;
    logic [3:0]       hold_wen;
    logic [31:0]      hold_addr;
    logic [31:0]      hold_wdata;

    logic run;
    logic both;
    logic win1;
    logic any_gnt;

    assign run     = resetn & ~mem_stall;
    assign both    = req0_en & req1_en;
    assign any_gnt = req0_gnt | req1_gnt;

    // Grant decision: a lone requester wins, a conflict goes to prio_ptr (RR) or port 0.
    always_comb begin
        win1     = 1'b0;
        req0_gnt = 1'b0;
        req1_gnt = 1'b0;
        if (run) begin
            if (both) begin
                win1     = RR ? prio_ptr : 1'b0;
                req0_gnt = ~win1;
                req1_gnt = win1;
            end else begin
                req0_gnt = req0_en;
                req1_gnt = req1_en;
            end
        end
    end

    // SRAM request mux: the held last grant while stalled, else the granted port, else idle.
    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0;
        data_sram_addr  = 32'b0;
        data_sram_wdata = 32'b0;
        if (mem_stall) begin
            data_sram_en    = hold_en;
            data_sram_wen   = hold_wen;
            data_sram_addr  = hold_addr;
            data_sram_wdata = hold_wdata;
        end else if (req0_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = req0_wen;
            data_sram_addr  = req0_addr;
            data_sram_wdata = req0_wdata;
        end else if (req1_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = req1_wen;
            data_sram_addr  = req1_addr;
            data_sram_wdata = req1_wdata;
        end
    end

    // Priority pointer, return pipe, held request and saturating conflict counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prio_ptr   <= 1'b0;
            ret_valid  <= 1'b0;
            ret_sel    <= 1'b0;
            cnt_q      <= '0;
            hold_en    <= 1'b0;
            hold_wen   <= 4'b0;
            hold_addr  <= 32'b0;
            hold_wdata <= 32'b0;
        end else if (!mem_stall) begin
            ret_valid <= any_gnt & (data_sram_wen == 4'b0);
            ret_sel   <= req1_gnt;
            if (RR && both) begin
                prio_ptr <= ~win1;
            end
            if (both && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (any_gnt) begin
                hold_en    <= data_sram_en;
                hold_wen   <= data_sram_wen;
                hold_addr  <= data_sram_addr;
                hold_wdata <= data_sram_wdata;
            end
        end
    end

    assign conflict_cnt = cnt_q;

    // Load return: visible only out of reset and while not stalled; data zeroed otherwise.
    assign req0_rvalid = resetn & ret_valid & ~ret_sel & ~mem_stall;
    assign req1_rvalid = resetn & ret_valid &  ret_sel & ~mem_stall;
    assign req0_rdata  = req0_rvalid ? data_sram_rdata : 32'b0;
    assign req1_rdata  = req1_rvalid ? data_sram_rdata : 32'b0;

endmodule

// File: tb/tb_dsram_port_arb.sv
// Bench for dsram_port_arb: round-robin instance (dut) plus a fixed-priority
// instance with a narrow counter (fp) sharing all inputs and the SRAM model.
module tb_dsram_port_arb;

    logic        clk = 1'b0;
    logic        resetn, mem_stall;
    logic        req0_en, req1_en;
    logic [3:0]  req0_wen, req1_wen;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        req0_gnt, req0_rvalid, req1_gnt, req1_rvalid;
    logic [31:0] req0_rdata, req1_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [31:0] data_sram_rdata = 32'b0;
    logic [15:0] conflict_cnt;

    logic        fp_req0_gnt, fp_req0_rvalid, fp_req1_gnt, fp_req1_rvalid;
    logic [31:0] fp_req0_rdata, fp_req1_rdata;
    logic        fp_sram_en;
    logic [3:0]  fp_sram_wen;
    logic [31:0] fp_sram_addr, fp_sram_wdata;
    logic [2:0]  fp_conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];

    // clock/reset block
    always #5 clk = ~clk;

    dsram_port_arb #(.RR(1'b1), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .mem_stall(mem_stall),
        .req0_en(req0_en), .req0_wen(req0_wen), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_gnt(req0_gnt), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_en(req1_en), .req1_wen(req1_wen), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_gnt(req1_gnt), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .conflict_cnt(conflict_cnt)
    );

    dsram_port_arb #(.RR(1'b0), .CNT_W(3)) fp (
        .clk(clk), .resetn(resetn), .mem_stall(mem_stall),
        .req0_en(req0_en), .req0_wen(req0_wen), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_gnt(fp_req0_gnt), .req0_rvalid(fp_req0_rvalid), .req0_rdata(fp_req0_rdata),
        .req1_en(req1_en), .req1_wen(req1_wen), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_gnt(fp_req1_gnt), .req1_rvalid(fp_req1_rvalid), .req1_rdata(fp_req1_rdata),
        .data_sram_en(fp_sram_en), .data_sram_wen(fp_sram_wen),
        .data_sram_addr(fp_sram_addr), .data_sram_wdata(fp_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .conflict_cnt(fp_conflict_cnt)
    );

    function automatic logic [31:0] sram_f(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // SRAM model: read data appears one cycle after an enabled read of the dut request
    always @(posedge clk) begin
        if (data_sram_en && data_sram_wen == 4'b0) data_sram_rdata <= sram_f(data_sram_addr);
    end

    // scoreboard: every rvalid pops one expected {port, data}
    always @(negedge clk) begin
        logic [32:0] e;
        #2;
        if (req0_rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++; $display("FAIL sb_port0 got rdata=%h, expected no rvalid", req0_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({1'b0, req0_rdata} !== e) begin
                    n_errors++; $display("FAIL sb_port0 got %h, expected %h", {1'b0, req0_rdata}, e);
                end
            end
        end
        if (req1_rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++; $display("FAIL sb_port1 got rdata=%h, expected no rvalid", req1_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({1'b1, req1_rdata} !== e) begin
                    n_errors++; $display("FAIL sb_port1 got %h, expected %h", {1'b1, req1_rdata}, e);
                end
            end
        end
    end

    // driver tasks
    task automatic idle_inputs;
        mem_stall = 1'b0;
        req0_en = 1'b0; req0_wen = 4'b0; req0_addr = 32'b0; req0_wdata = 32'b0;
        req1_en = 1'b0; req1_wen = 4'b0; req1_addr = 32'b0; req1_wdata = 32'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({req0_gnt, req1_gnt, req0_rvalid, req1_rvalid, data_sram_en, data_sram_wen} !== 9'b0 ||
            {req0_rdata, req1_rdata, data_sram_addr, data_sram_wdata} !== 128'b0 || conflict_cnt !== 16'd0) begin
            n_errors++; $display("FAIL reset_outputs got gnt=%b%b rv=%b%b en=%b cnt=%0d, expected all 0",
                                 req0_gnt, req1_gnt, req0_rvalid, req1_rvalid, data_sram_en, conflict_cnt);
        end
        n_checks++;
        if ({fp_req0_gnt, fp_req1_gnt, fp_sram_en, fp_conflict_cnt} !== 6'b0) begin
            n_errors++; $display("FAIL reset_fp got gnt=%b%b en=%b cnt=%0d, expected 0", fp_req0_gnt, fp_req1_gnt, fp_sram_en, fp_conflict_cnt);
        end
        resetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_single_load;
        do_reset();
        @(negedge clk);
        req0_en = 1'b1; req0_wen = 4'b0; req0_addr = 32'h100;
        #1;
        n_checks++;
        if (req0_gnt !== 1'b1 || req1_gnt !== 1'b0 || data_sram_en !== 1'b1 || data_sram_addr !== 32'h100 || data_sram_wen !== 4'b0) begin
            n_errors++; $display("FAIL single_grant got gnt=%b%b en=%b addr=%h, expected gnt0 addr 100", req0_gnt, req1_gnt, data_sram_en, data_sram_addr);
        end
        exp_q.push_back({1'b0, sram_f(32'h100)});
        @(negedge clk);
        req0_en = 1'b0;
        #1;
        n_checks++;
        if (req0_rvalid !== 1'b1 || req0_rdata !== 32'hDEADBEEF || req1_rvalid !== 1'b0) begin
            n_errors++; $display("FAIL single_return got rv0=%b rdata0=%h rv1=%b, expected 1 deadbeef 0", req0_rvalid, req0_rdata, req1_rvalid);
        end
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req0_en = 1'b1; req0_wen = 4'b0; req0_addr = 32'h10;
            req1_en = 1'b1; req1_wen = 4'b0; req1_addr = 32'h20;
            #1;
            n_checks++;
            if (req0_gnt !== (k % 2 == 0) || req1_gnt !== (k % 2 == 1) ||
                data_sram_addr !== ((k % 2 == 0) ? 32'h10 : 32'h20)) begin
                n_errors++; $display("FAIL rr_grant cycle %0d got gnt=%b%b addr=%h", k, req0_gnt, req1_gnt, data_sram_addr);
            end
            if (k > 0) begin
                n_checks++;
                if (req0_rvalid !== (k % 2 == 1) || req1_rvalid !== (k % 2 == 0)) begin
                    n_errors++; $display("FAIL rr_rvalid cycle %0d got rv=%b%b", k, req0_rvalid, req1_rvalid);
                end
            end
            exp_q.push_back((k % 2 == 0) ? {1'b0, sram_f(32'h10)} : {1'b1, sram_f(32'h20)});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if (req1_rvalid !== 1'b1 || req0_rvalid !== 1'b0 || conflict_cnt !== 16'd4) begin
            n_errors++; $display("FAIL rr_tail got rv=%b%b cnt=%0d, expected rv1 cnt=4", req0_rvalid, req1_rvalid, conflict_cnt);
        end
    endtask

    task automatic test_fixed_priority;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req0_en = 1'b1; req0_wen = 4'hF; req0_addr = 32'h30;
            req1_en = 1'b1; req1_wen = 4'hF; req1_addr = 32'h40;
            #1;
            n_checks++;
            if (fp_req0_gnt !== 1'b1 || fp_req1_gnt !== 1'b0 || fp_sram_addr !== 32'h30) begin
                n_errors++; $display("FAIL fixed_grant cycle %0d got gnt=%b%b addr=%h, expected gnt0", k, fp_req0_gnt, fp_req1_gnt, fp_sram_addr);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if (fp_conflict_cnt !== 3'd3) begin
            n_errors++; $display("FAIL fixed_cnt got %0d, expected 3", fp_conflict_cnt);
        end
    endtask

    task automatic test_store;
        do_reset();
        @(negedge clk);
        req1_en = 1'b1; req1_wen = 4'b0011; req1_addr = 32'h204; req1_wdata = 32'h1234;
        #1;
        n_checks++;
        if (req1_gnt !== 1'b1 || req0_gnt !== 1'b0 || data_sram_wen !== 4'b0011 ||
            data_sram_addr !== 32'h204 || data_sram_wdata !== 32'h1234 || data_sram_en !== 1'b1) begin
            n_errors++; $display("FAIL store_mux got gnt1=%b wen=%b addr=%h wdata=%h", req1_gnt, data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin
            n_errors++; $display("FAIL store_no_rvalid got rv=%b%b, expected 00", req0_rvalid, req1_rvalid);
        end
    endtask

    task automatic test_stall;
        do_reset();
        @(negedge clk);
        req0_en = 1'b1; req0_wen = 4'b0; req0_addr = 32'h300;
        #1;
        n_checks++;
        if (req0_gnt !== 1'b1) begin
            n_errors++; $display("FAIL stall_pre_grant got %b, expected 1", req0_gnt);
        end
        exp_q.push_back({1'b0, sram_f(32'h300)});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_stall = 1'b1;
            req0_en = 1'b0; req0_addr = 32'h0;
            req1_en = 1'b1; req1_wen = 4'b0; req1_addr = 32'h400;
            #1;
            n_checks++;
            if (req0_gnt !== 1'b0 || req1_gnt !== 1'b0 || req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0 ||
                data_sram_en !== 1'b1 || data_sram_addr !== 32'h300 || data_sram_wen !== 4'b0) begin
                n_errors++; $display("FAIL stall_hold cycle %0d got gnt=%b%b rv=%b%b en=%b addr=%h", k,
                                     req0_gnt, req1_gnt, req0_rvalid, req1_rvalid, data_sram_en, data_sram_addr);
            end
        end
        @(negedge clk);
        mem_stall = 1'b0;
        #1;
        n_checks++;
        if (req0_rvalid !== 1'b1 || req0_rdata !== sram_f(32'h300) || req1_gnt !== 1'b1 || data_sram_addr !== 32'h400) begin
            n_errors++; $display("FAIL stall_release got rv0=%b rdata0=%h gnt1=%b addr=%h", req0_rvalid, req0_rdata, req1_gnt, data_sram_addr);
        end
        exp_q.push_back({1'b1, sram_f(32'h400)});
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if (req1_rvalid !== 1'b1 || req1_rdata !== sram_f(32'h400) || conflict_cnt !== 16'd0) begin
            n_errors++; $display("FAIL stall_after got rv1=%b rdata1=%h cnt=%0d", req1_rvalid, req1_rdata, conflict_cnt);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        @(negedge clk);
        req0_en = 1'b1; req0_wen = 4'b0; req0_addr = 32'h500;
        req1_en = 1'b1; req1_wen = 4'b0; req1_addr = 32'h600;
        #1;
        n_checks++;
        if (req0_gnt !== 1'b1 || req1_gnt !== 1'b0) begin
            n_errors++; $display("FAIL rst_mid_grant got gnt=%b%b, expected 10", req0_gnt, req1_gnt);
        end
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        #1;
        n_checks++;
        if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0 || req0_rdata !== 32'b0) begin
            n_errors++; $display("FAIL rst_mid_rvalid got rv=%b%b rdata0=%h, expected none", req0_rvalid, req1_rvalid, req0_rdata);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_checks++;
        if ({req0_gnt, req1_gnt, req0_rvalid, req1_rvalid, data_sram_en, data_sram_wen} !== 9'b0 ||
            conflict_cnt !== 16'd0 || fp_conflict_cnt !== 3'd0) begin
            n_errors++; $display("FAIL rst_mid_after got rv=%b%b en=%b cnt=%0d fpcnt=%0d, expected 0",
                                 req0_rvalid, req1_rvalid, data_sram_en, conflict_cnt, fp_conflict_cnt);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req0_en = 1'b1; req0_wen = 4'h1; req0_addr = 32'h700;
            req1_en = 1'b1; req1_wen = 4'h2; req1_addr = 32'h704;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if (fp_conflict_cnt !== 3'd7 || conflict_cnt !== 16'd10) begin
            n_errors++; $display("FAIL cnt_saturate got fp=%0d rr=%0d, expected 7 10", fp_conflict_cnt, conflict_cnt);
        end
    endtask

    task automatic test_random;
        logic        p0, p1, g0, g1, prio_m;
        logic [3:0]  w0, w1;
        logic [31:0] a0, a1;
        int          cnt_m;
        do_reset();
        prio_m = 1'b0; cnt_m = 0; p0 = 1'b0; p1 = 1'b0;
        w0 = 4'b0; w1 = 4'b0; a0 = 32'b0; a1 = 32'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!p0) begin
                p0 = 1'($urandom_range(0, 1));
                a0 = 32'($urandom_range(0, 1023)) << 2;
                w0 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            end
            if (!p1) begin
                p1 = 1'($urandom_range(0, 1));
                a1 = 32'($urandom_range(0, 1023)) << 2;
                w1 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            end
            req0_en = p0; req0_wen = w0; req0_addr = a0; req0_wdata = a0 ^ 32'hFFFF;
            req1_en = p1; req1_wen = w1; req1_addr = a1; req1_wdata = a1 ^ 32'hAAAA;
            if (p0 && p1) begin
                g1 = prio_m; g0 = ~prio_m; prio_m = ~prio_m; cnt_m++;
            end else begin
                g0 = p0; g1 = p1;
            end
            #1;
            n_checks++;
            if (req0_gnt !== g0 || req1_gnt !== g1 || data_sram_en !== (g0 | g1) ||
                ((g0 | g1) && (data_sram_addr !== (g1 ? a1 : a0) || data_sram_wen !== (g1 ? w1 : w0)))) begin
                n_errors++; $display("FAIL rand_grant cycle %0d got gnt=%b%b addr=%h, expected gnt=%b%b", k,
                                     req0_gnt, req1_gnt, data_sram_addr, g0, g1);
            end
            if (g0 && w0 == 4'b0) exp_q.push_back({1'b0, sram_f(a0)});
            if (g1 && w1 == 4'b0) exp_q.push_back({1'b1, sram_f(a1)});
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if (conflict_cnt !== 16'(cnt_m) || fp_conflict_cnt !== ((cnt_m > 7) ? 3'd7 : 3'(cnt_m))) begin
            n_errors++; $display("FAIL rand_cnt got rr=%0d fp=%0d, expected %0d", conflict_cnt, fp_conflict_cnt, cnt_m);
        end
        @(negedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL rand_drain got %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_single_load();
        test_round_robin();
        test_fixed_priority();
        test_store();
        test_stall();
        test_reset_mid();
        test_saturation();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
